// File: rtl/output_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// output_conditioner_pkg
//
// Purpose:
//   Shared definitions for the output conditioner and the planned
//   multi-channel driver:
//     - FSM state encoding (STATE_IDLE / STATE_DWELL)
//     - request-priority encoding (REQ_NONE / REQ_SET / REQ_CLEAR / REQ_TOGGLE)
//     - helpers that turn raw request pulses into a single request and then
//       into a target level.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package output_conditioner_pkg;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_DWELL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_SET    = 2'd1,
        REQ_CLEAR  = 2'd2,
        REQ_TOGGLE = 2'd3
    } req_t;

    // Priority: clear over set, and either of them masks toggle.
    function automatic req_t encode_request(
        input logic setpulse,
        input logic clearpulse,
        input logic togglepulse
    );
        req_t req;
        if (clearpulse) begin
            req = REQ_CLEAR;
        end else if (setpulse) begin
            req = REQ_SET;
        end else if (togglepulse) begin
            req = REQ_TOGGLE;
        end else begin
            req = REQ_NONE;
        end
        return req;
    endfunction

    // Level the channel should end up at. 'effective' is the queued target
    // when a transition is pending, otherwise the current driven level, so a
    // toggle always inverts what the output is heading towards.
    function automatic logic resolve_level(
        input req_t req,
        input logic effective
    );
        logic level;
        case (req)
            REQ_SET:    level = 1'b1;
            REQ_CLEAR:  level = 1'b0;
            REQ_TOGGLE: level = ~effective;
            default:    level = effective;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/output_conditioner_dwell_timer.sv
// -----------------------------------------------------------------------------
// output_conditioner_dwell_timer
//
// Purpose:
//   Dwell counter for the output conditioner. Counts clock cycles since the
//   last restart and flags the final cycle of the dwell interval.
//
// Parameters:
//   counterwidth  counter width in bits; 2^counterwidth >= mindwell
//   mindwell      dwell length in cycles, 1 .. 2^counterwidth
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset, clears the count
//   restart  in   load 0 on the next edge (has priority over enable)
//   enable   in   increment on the next edge
//   done     out  high while the count equals mindwell-1
// -----------------------------------------------------------------------------
module output_conditioner_dwell_timer #(
    parameter int counterwidth = 3,
    parameter int mindwell     = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic done
);

    localparam logic [counterwidth-1:0] LAST = counterwidth'(mindwell - 1);
    localparam logic [counterwidth-1:0] ONE  = counterwidth'(1);

    generate
        if (mindwell < 1 || mindwell > (1 << counterwidth)) begin : g_bad_param
            $error("output_conditioner_dwell_timer: mindwell out of range for counterwidth");
        end
    endgenerate

    logic [counterwidth-1:0] count;

    // The owner restarts the counter whenever done is seen, so the count never
    // advances past LAST and cannot wrap, even when LAST is all ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/output_conditioner.sv
// -----------------------------------------------------------------------------
// output_conditioner
//
// Purpose:
//   Turns single-cycle set / clear / toggle requests into a clean level on
//   drivensignal that, once changed, is held for at least mindwell cycles.
//   Requests arriving during the hold are folded into a single queued target
//   which is applied exactly at the end of the hold if it still differs from
//   the driven level. Each transition produces a one-cycle edge pulse.
//
// Parameters:
//   counterwidth  dwell counter width; 2^counterwidth >= mindwell
//   mindwell      minimum hold time in cycles, 1 .. 2^counterwidth
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   synchronous active-low reset, overrides all requests
//   setpulse      in   request drivensignal = 1
//   clearpulse    in   request drivensignal = 0 (beats setpulse)
//   togglepulse   in   request inversion of the effective target
//   drivensignal  out  conditioned level (registered)
//   positiveedge  out  high in the first cycle drivensignal = 1
//   negativeedge  out  high in the first cycle drivensignal = 0
//   busy          out  hold interval active
//   pending       out  a deferred transition is queued
// -----------------------------------------------------------------------------
import output_conditioner_pkg::*;

module output_conditioner #(
    parameter int counterwidth = 3,
    parameter int mindwell     = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic setpulse,
    input  logic clearpulse,
    input  logic togglepulse,
    output logic drivensignal,
    output logic positiveedge,
    output logic negativeedge,
    output logic busy,
    output logic pending
);

    state_t state;
    logic   target;

    req_t   req;
    logic   effective;
    logic   resolved;
    logic   dwell_done;
    logic   decide;
    logic   take_transition;
    logic   timer_restart;
    logic   timer_enable;

    // Request resolution
    assign req       = encode_request(setpulse, clearpulse, togglepulse);
    assign effective = pending ? target : drivensignal;
    assign resolved  = resolve_level(req, effective);

    // A decision is made every cycle in IDLE and on the last cycle of a
    // hold. A same-cycle request takes part in that decision.
    assign decide          = (state == STATE_IDLE) || dwell_done;
    assign take_transition = decide && (resolved != drivensignal);

    // Restarting on every decision cycle both zeroes the count after a
    // transition and parks it at 0 while IDLE.
    assign timer_restart = decide;
    assign timer_enable  = (state == STATE_DWELL);

    output_conditioner_dwell_timer #(
        .counterwidth (counterwidth),
        .mindwell     (mindwell)
    ) u_dwell_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (timer_restart),
        .enable  (timer_enable),
        .done    (dwell_done)
    );

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= STATE_IDLE;
            target       <= 1'b0;
            drivensignal <= 1'b0;
            positiveedge <= 1'b0;
            negativeedge <= 1'b0;
            busy         <= 1'b0;
            pending      <= 1'b0;
        end else begin
            positiveedge <= 1'b0;
            negativeedge <= 1'b0;

            if (take_transition) begin
                // Applies from IDLE and at hold end alike; a new hold starts.
                drivensignal <= resolved;
                positiveedge <= resolved;
                negativeedge <= ~resolved;
                target       <= resolved;
                pending      <= 1'b0;
                state        <= STATE_DWELL;
                busy         <= 1'b1;
            end else if (state == STATE_DWELL) begin
                if (dwell_done) begin
                    // Queued target ended equal to the output: nothing to do.
                    target  <= drivensignal;
                    pending <= 1'b0;
                    state   <= STATE_IDLE;
                    busy    <= 1'b0;
                end else begin
                    // Inside the hold requests only move the queued target;
                    // opposite requests can therefore cancel each other.
                    target  <= resolved;
                    pending <= (resolved != drivensignal);
                end
            end
        end
    end

endmodule

// File: tb/tb_output_conditioner.sv
// -----------------------------------------------------------------------------
// tb_output_conditioner
//
// Directed bench for output_conditioner with mindwell = 3. Each step drives
// one cycle of inputs, waits for the rising edge and compares the outputs of
// the following cycle, packed as {drivensignal, positiveedge, negativeedge,
// busy, pending}, against hand-computed values.
// -----------------------------------------------------------------------------
module tb_output_conditioner;

    logic clk;
    logic reset_n;
    logic setpulse;
    logic clearpulse;
    logic togglepulse;
    logic drivensignal;
    logic positiveedge;
    logic negativeedge;
    logic busy;
    logic pending;

    int checks;
    int errors;

    output_conditioner #(
        .counterwidth (3),
        .mindwell     (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .setpulse     (setpulse),
        .clearpulse   (clearpulse),
        .togglepulse  (togglepulse),
        .drivensignal (drivensignal),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge),
        .busy         (busy),
        .pending      (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {ds,pe,ne,busy,pend}=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs of the next cycle.
    task automatic step(
        input string      tag,
        input logic       rstn,
        input logic       s,
        input logic       c,
        input logic       t,
        input logic [4:0] exp
    );
        reset_n     = rstn;
        setpulse    = s;
        clearpulse  = c;
        togglepulse = t;
        @(posedge clk);
        #1;
        check(tag, {drivensignal, positiveedge, negativeedge, busy, pending}, exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        setpulse    = 1'b1;
        clearpulse  = 1'b0;
        togglepulse = 1'b0;

        // Reset held with setpulse asserted, then released idle
        step("rst_c1",      1'b0, 1'b1, 1'b0, 1'b0, 5'b00000);
        step("rst_c2",      1'b0, 1'b1, 1'b0, 1'b0, 5'b00000);
        step("rst_release", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

        // Single set
        step("set_c1", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11010);
        step("set_c2", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010);
        step("set_c3", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010);
        step("set_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000);

        // Clear back to 0 from IDLE
        step("clr_c1", 1'b1, 1'b0, 1'b1, 1'b0, 5'b00110);
        step("clr_c2", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("clr_c3", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("clr_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

        // Queued reversal: set then clear during the hold
        step("qrev_c1", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11010);
        step("qrev_c2", 1'b1, 1'b0, 1'b1, 1'b0, 5'b10011);
        step("qrev_c3", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011);
        step("qrev_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00110);
        step("qrev_c5", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("qrev_c6", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("qrev_c7", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

        // Cancelled toggles: two toggles during the hold cancel out
        step("ctog_c1", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11010);
        step("ctog_c2", 1'b1, 1'b0, 1'b0, 1'b1, 5'b10011);
        step("ctog_c3", 1'b1, 1'b0, 1'b0, 1'b1, 5'b10010);
        step("ctog_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000);

        // Request equal to the current level in IDLE has no effect
        step("same_set", 1'b1, 1'b1, 1'b0, 1'b0, 5'b10000);

        // Priority: all three requests at once from level 1 -> clear wins
        step("prio_all_c1", 1'b1, 1'b1, 1'b1, 1'b1, 5'b00110);
        step("prio_all_c2", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("prio_all_c3", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("prio_all_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

        // Priority: set + toggle from level 0 -> rises, toggle ignored
        step("prio_st_c1", 1'b1, 1'b1, 1'b0, 1'b1, 5'b11010);
        step("prio_st_c2", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010);
        step("prio_st_c3", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010);
        step("prio_st_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000);

        // Toggle from IDLE at level 1 falls
        step("tog_idle_c1", 1'b1, 1'b0, 1'b0, 1'b1, 5'b00110);
        step("tog_idle_c2", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("tog_idle_c3", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        step("tog_idle_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

        // Reset in the middle of a hold with a queued reversal
        step("rmid_c1", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11010);
        step("rmid_c2", 1'b1, 1'b0, 1'b1, 1'b0, 5'b10011);
        step("rmid_c3", 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        step("rmid_c4", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        step("rmid_c5", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11010);
        step("rmid_c6", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010);
        step("rmid_c7", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10010);
        step("rmid_c8", 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
